axis_wrr_arbiter: RTL
=====================

AXIS_WRR_ARBITER -- requirements
Module: axis_wrr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, tdata width of every port.
REQ-002 The block SHALL have parameter WEIGHT_A, default 1, packets port s0a may send per turn (1..15).
REQ-003 The block SHALL have parameter WEIGHT_B, default 2, packets per turn for s0b (1..15).
REQ-004 The block SHALL have parameter WEIGHT_C, default 4, packets per turn for s0c (1..15).
REQ-005 The block SHALL have port axis_aclk, input, 1, the single clock; every register is updated on its rising edge.
REQ-006 The block SHALL have port axis_areset, input, 1, synchronous active-high reset.
REQ-007 For each x in {a,b,c}, the block SHALL have s0x_axis_tdata (in, DATA_W), s0x_axis_tvalid (in, 1), s0x_axis_tready (out, 1) and s0x_axis_tlast (in, 1), forming an AXI-stream slave.
REQ-008 The block SHALL have m0k_axis_tdata (out, DATA_W), m0k_axis_tvalid (out, 1), m0k_axis_tready (in, 1) and m0k_axis_tlast (out, 1), forming an AXI-stream master.
REQ-009 The block SHALL have grant (out, 3), the one-hot owner of m0k: bit0=a, bit1=b, bit2=c; 000 when idle.
REQ-010 The block SHALL have pkt_cnt_a, pkt_cnt_b and pkt_cnt_c (out, 16 each): packets forwarded per port, saturating at 0xFFFF.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-012 In IDLE: grant=000, m0k_axis_tvalid=0, all s0x_axis_tready=0.
REQ-013 In IDLE with any s0x_axis_tvalid=1, the block SHALL register a winner and enter GRANT the next cycle; arbitration latency is 1 cycle.
REQ-014 Winner selection: if the last owner has credit>0 and its tvalid=1, keep it; otherwise search round-robin starting at last owner+1 (a->b->c->a) and take the first with tvalid=1.
REQ-015 When a port wins via the round-robin search (REQ-014), its credit SHALL load that port's WEIGHT_x.
REQ-016 In GRANT, m0k tdata/tvalid/tlast SHALL combinationally mirror the granted port, its tready SHALL equal m0k_axis_tready, and non-granted treadys SHALL be 0; the data path adds zero latency.
REQ-017 Grant SHALL be held for the whole packet, until a beat with tvalid&tready&tlast is accepted; tvalid gaps mid-packet SHALL NOT release the grant.
REQ-018 On that tlast handshake: credit decrements by 1, the port's pkt_cnt increments (saturating), the last owner is recorded, and the FSM returns to IDLE; there is 1 bubble cycle between packets.
REQ-019 A single-beat packet (tlast on first beat) SHALL obey REQ-018 identically.
REQ-020 If only one port requests, it SHALL be re-granted indefinitely; when its credit is 0, the search wraps to itself and reloads its credit.
REQ-021 Simultaneous requests from IDLE with no credit remaining SHALL resolve strictly by REQ-014 order.
REQ-022 Credit SHALL be a 4-bit counter and SHALL never underflow.

Reset
REQ-023 While axis_areset=1 at a clock edge: state=IDLE, grant=000, credit=0, last owner=c (so a has first priority), and all pkt_cnt=0.
REQ-024 Outputs SHALL show reset values in the cycle after a reset edge: m0k_axis_tvalid=0 and all s0x_axis_tready=0.
REQ-025 Reset asserted mid-packet SHALL abort the packet without emitting tlast; after reset, arbitration restarts per REQ-014.

Verification
REQ-026 Scenario: after reset, s0a sends a 10-beat packet (data 1..10, tlast on 10) -> m0k receives 1..10 with tlast on beat 10, grant=001 during it, and pkt_cnt_a=1.
REQ-027 Scenario: a, b and c each continuously offer 1-beat packets -> order on m0k is a, b, b, c, c, c, c, a, b, b, ..., with 1 bubble cycle between packets.
REQ-028 Scenario: m0k_axis_tready toggles 1/0 during an s0b 4-beat packet -> no beat is lost or duplicated, s0b_axis_tready tracks m0k_axis_tready, and s0a_axis_tready and s0c_axis_tready stay 0.
REQ-029 Scenario: s0c deasserts tvalid for 3 cycles mid-packet while s0a is valid -> grant stays 100 until s0c's tlast.
REQ-030 Scenario: reset pulses during beat 3 of a 6-beat s0a packet -> the next cycle shows grant=000, m0k_axis_tvalid=0 and pkt_cnt_a=0.
REQ-031 Scenario: force pkt_cnt_b to 0xFFFF, then s0b sends 1 packet -> pkt_cnt_b remains 0xFFFF.

Source files
------------

// File: rtl/axis_wrr_arbiter.sv
// Three-input AXI-stream packet arbiter with weighted round-robin (per-port packet credits).
// The owner holds the master for a whole packet; one idle cycle separates consecutive packets.
module axis_wrr_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WEIGHT_A = 1,
    parameter int unsigned WEIGHT_B = 2,
    parameter int unsigned WEIGHT_C = 4
) (
    input  logic              axis_aclk,
    input  logic              axis_areset,

    input  logic [DATA_W-1:0] s0a_axis_tdata,
    input  logic              s0a_axis_tvalid,
    output logic              s0a_axis_tready,
    input  logic              s0a_axis_tlast,

    input  logic [DATA_W-1:0] s0b_axis_tdata,
    input  logic              s0b_axis_tvalid,
    output logic              s0b_axis_tready,
    input  logic              s0b_axis_tlast,

    input  logic [DATA_W-1:0] s0c_axis_tdata,
    input  logic              s0c_axis_tvalid,
    output logic              s0c_axis_tready,
    input  logic              s0c_axis_tlast,

    output logic [DATA_W-1:0] m0k_axis_tdata,
    output logic              m0k_axis_tvalid,
    input  logic              m0k_axis_tready,
    output logic              m0k_axis_tlast,

    output logic [2:0]        grant,
    output logic [15:0]       pkt_cnt_a,
    output logic [15:0]       pkt_cnt_b,
    output logic [15:0]       pkt_cnt_c
);

    typedef enum logic {StIdle, StGrant} state_t;

    localparam logic [1:0] PortA = 2'd0;
    localparam logic [1:0] PortB = 2'd1;
    localparam logic [1:0] PortC = 2'd2;

    state_t     state_q;
    logic [3:0] credit_q;
    logic [1:0] last_owner_q;
    logic [1:0] owner_q;

    logic [2:0] req;
    logic       win_found;
    logic       win_reload;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       accept_last;

    assign req = {s0c_axis_tvalid, s0b_axis_tvalid, s0a_axis_tvalid};

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PortC) ? PortA : p + 2'd1;
    endfunction

    function automatic logic [3:0] port_weight(input logic [1:0] p);
        logic [3:0] w;
        unique case (p)
            PortA:   w = 4'(WEIGHT_A);
            PortB:   w = 4'(WEIGHT_B);
            default: w = 4'(WEIGHT_C);
        endcase
        return w;
    endfunction

    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        logic [2:0] oh;
        unique case (p)
            PortA:   oh = 3'b001;
            PortB:   oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The last owner keeps the bus while it has credit left; otherwise search starting after it.
    always_comb begin
        win_found  = 1'b0;
        win_reload = 1'b0;
        win_idx    = last_owner_q;
        cand       = last_owner_q;
        if (credit_q != 4'd0 && req[last_owner_q]) begin
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                cand = next_port(cand);
                if (!win_found && req[cand]) begin
                    win_found  = 1'b1;
                    win_reload = 1'b1;
                    win_idx    = cand;
                end
            end
        end
    end

    // Zero-latency data path; grant is 000 outside a packet so everything idles low.
    always_comb begin
        m0k_axis_tdata  = '0;
        m0k_axis_tvalid = 1'b0;
        m0k_axis_tlast  = 1'b0;
        s0a_axis_tready = 1'b0;
        s0b_axis_tready = 1'b0;
        s0c_axis_tready = 1'b0;
        unique case (grant)
            3'b001: begin
                m0k_axis_tdata  = s0a_axis_tdata;
                m0k_axis_tvalid = s0a_axis_tvalid;
                m0k_axis_tlast  = s0a_axis_tlast;
                s0a_axis_tready = m0k_axis_tready;
            end
            3'b010: begin
                m0k_axis_tdata  = s0b_axis_tdata;
                m0k_axis_tvalid = s0b_axis_tvalid;
                m0k_axis_tlast  = s0b_axis_tlast;
                s0b_axis_tready = m0k_axis_tready;
            end
            3'b100: begin
                m0k_axis_tdata  = s0c_axis_tdata;
                m0k_axis_tvalid = s0c_axis_tvalid;
                m0k_axis_tlast  = s0c_axis_tlast;
                s0c_axis_tready = m0k_axis_tready;
            end
            default: ;
        endcase
    end

    assign accept_last = (state_q == StGrant) && m0k_axis_tvalid && m0k_axis_tready
                         && m0k_axis_tlast;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q      <= StIdle;
            grant        <= 3'b000;
            credit_q     <= 4'd0;
            last_owner_q <= PortC;
            owner_q      <= PortC;
            pkt_cnt_a    <= 16'd0;
            pkt_cnt_b    <= 16'd0;
            pkt_cnt_c    <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q <= StGrant;
                        grant   <= port_onehot(win_idx);
                        owner_q <= win_idx;
                        if (win_reload) begin
                            credit_q <= port_weight(win_idx);
                        end
                    end
                end
                StGrant: begin
                    if (accept_last) begin
                        state_q      <= StIdle;
                        grant        <= 3'b000;
                        last_owner_q <= owner_q;
                        if (credit_q != 4'd0) begin
                            credit_q <= credit_q - 4'd1;
                        end
                        unique case (owner_q)
                            PortA:   pkt_cnt_a <= sat_inc(pkt_cnt_a);
                            PortB:   pkt_cnt_b <= sat_inc(pkt_cnt_b);
                            default: pkt_cnt_c <= sat_inc(pkt_cnt_c);
                        endcase
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
